// File: rtl/jtag_tap_driver.sv
// Host-side JTAG initiator: serialises IR/DR scan requests onto TCK/TMS/TDI,
// tracks the TAP state itself and returns the TDO bits captured while shifting.
module jtag_tap_driver #(
   parameter int unsigned ClkDiv = 4,
   parameter int unsigned MaxLen = 64,
   localparam int unsigned LenW = $clog2(MaxLen + 1)
) (
   input  logic              clk_i,
   input  logic              trst_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_ir_i,
   input  logic              req_reset_i,
   input  logic [LenW-1:0]   req_len_i,
   input  logic [MaxLen-1:0] req_data_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [MaxLen-1:0] rsp_data_o,
   output logic              tck_o,
   output logic              tms_o,
   output logic              tdi_o,
   input  logic              tdo_i
);

   localparam int unsigned DivW = $clog2(ClkDiv + 1);

   localparam logic [2:0] RST_SEQ = 3'd0;
   localparam logic [2:0] IDLE    = 3'd1;
   localparam logic [2:0] SEL     = 3'd2;
   localparam logic [2:0] SHIFT   = 3'd3;
   localparam logic [2:0] EXIT    = 3'd4;
   localparam logic [2:0] UPD     = 3'd5;
   localparam logic [2:0] RSP     = 3'd6;

   logic [2:0]        state_q, state_d;
   logic [DivW-1:0]   div_q, div_d;
   logic [LenW-1:0]   cnt_q, cnt_d;
   logic [LenW-1:0]   len_q, len_d;
   logic              ir_q, ir_d;
   logic              rst_rsp_q, rst_rsp_d;
   logic [MaxLen-1:0] data_q, data_d;
   logic [MaxLen-1:0] cap_q, cap_d;
   logic              tck_q, tck_d;
   logic              tms_q, tms_d;
   logic              tdi_q, tdi_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [MaxLen-1:0] rsp_data_q, rsp_data_d;

   logic              running;
   logic              tick;
   logic              rise;
   logic              fall;
   logic              last_bit;
   logic [LenW-1:0]   len_clamp;

   assign running   = state_q inside {RST_SEQ, SEL, SHIFT, EXIT, UPD};
   assign tick      = running && (div_q == DivW'(ClkDiv - 1));
   assign rise      = tick && !tck_q;
   assign fall      = tick && tck_q;
   assign len_clamp = (req_len_i > LenW'(MaxLen)) ? LenW'(MaxLen) : req_len_i;

   // Index of the final TCK within the current TAP-walking state
   always_comb begin
      last_bit = 1'b1;
      case (state_q)
         RST_SEQ: last_bit = (cnt_q == LenW'(5));
         SEL:     last_bit = (cnt_q == (ir_q ? LenW'(3) : LenW'(2)));
         SHIFT:   last_bit = (cnt_q == len_q - LenW'(1));
         default: last_bit = 1'b1;
      endcase
   end

   // Next-state and next-output logic; TMS/TDI only move on TCK falling edges
   always_comb begin
      state_d     = state_q;
      div_d       = '0;
      cnt_d       = cnt_q;
      len_d       = len_q;
      ir_d        = ir_q;
      rst_rsp_d   = rst_rsp_q;
      data_d      = data_q;
      cap_d       = cap_q;
      tck_d       = tck_q;
      tms_d       = tms_q;
      tdi_d       = tdi_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;

      if (running) begin
         div_d = tick ? '0 : div_q + DivW'(1);
      end
      if (tick) begin
         tck_d = ~tck_q;
      end
      if (rise && state_q == SHIFT) begin
         cap_d = {tdo_i, cap_q[MaxLen-1:1]};
      end

      case (state_q)
         RST_SEQ: begin
            if (fall) begin
               if (last_bit) begin
                  tms_d = 1'b0;
                  cnt_d = '0;
                  if (rst_rsp_q) begin
                     state_d = RSP;
                  end else begin
                     state_d     = IDLE;
                     req_ready_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + LenW'(1);
                  tms_d = (cnt_q < LenW'(4));
               end
            end
         end
         IDLE: begin
            tms_d = 1'b0;
            tdi_d = 1'b0;
            if (req_valid_i && req_ready_q) begin
               req_ready_d = 1'b0;
               cnt_d       = '0;
               cap_d       = '0;
               ir_d        = req_ir_i;
               data_d      = req_data_i;
               len_d       = len_clamp;
               rst_rsp_d   = 1'b0;
               if (req_reset_i) begin
                  state_d   = RST_SEQ;
                  rst_rsp_d = 1'b1;
                  len_d     = '0;
                  tms_d     = 1'b1;
               end else if (len_clamp == '0) begin
                  state_d = RSP;
               end else begin
                  state_d = SEL;
                  tms_d   = 1'b1;
               end
            end
         end
         SEL: begin
            if (fall) begin
               if (last_bit) begin
                  state_d = SHIFT;
                  cnt_d   = '0;
                  tms_d   = (len_q == LenW'(1));
                  tdi_d   = data_q[0];
               end else begin
                  cnt_d = cnt_q + LenW'(1);
                  tms_d = ir_q && (cnt_q == '0);
               end
            end
         end
         SHIFT: begin
            if (fall) begin
               if (last_bit) begin
                  state_d = EXIT;
                  cnt_d   = '0;
                  tms_d   = 1'b1;
                  tdi_d   = 1'b0;
               end else begin
                  cnt_d  = cnt_q + LenW'(1);
                  data_d = data_q >> 1;
                  tdi_d  = data_q[1];
                  tms_d  = (cnt_q + LenW'(2) == len_q);
               end
            end
         end
         EXIT: begin
            if (fall) begin
               state_d = UPD;
               tms_d   = 1'b0;
            end
         end
         UPD: begin
            if (fall) begin
               state_d = RSP;
               tms_d   = 1'b0;
            end
         end
         RSP: begin
            if (!rsp_valid_q) begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = rst_rsp_q ? '0 : cap_q >> (LenW'(MaxLen) - len_q);
            end else if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               rst_rsp_d   = 1'b0;
               state_d     = IDLE;
               req_ready_d = 1'b1;
            end
         end
         default: begin
            state_d = RST_SEQ;
            cnt_d   = '0;
            tck_d   = 1'b0;
            tms_d   = 1'b1;
         end
      endcase
   end

   // State and output registers; reset leaves the TAP walk armed to rerun
   always_ff @(posedge clk_i or negedge trst_ni) begin
      if (!trst_ni) begin
         state_q     <= RST_SEQ;
         div_q       <= '0;
         cnt_q       <= '0;
         len_q       <= '0;
         ir_q        <= 1'b0;
         rst_rsp_q   <= 1'b0;
         data_q      <= '0;
         cap_q       <= '0;
         tck_q       <= 1'b0;
         tms_q       <= 1'b1;
         tdi_q       <= 1'b0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         ir_q        <= ir_d;
         rst_rsp_q   <= rst_rsp_d;
         data_q      <= data_d;
         cap_q       <= cap_d;
         tck_q       <= tck_d;
         tms_q       <= tms_d;
         tdi_q       <= tdi_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign req_ready_o = req_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign tck_o       = tck_q;
   assign tms_o       = tms_q;
   assign tdi_o       = tdi_q;

endmodule

// File: tb/tb_jtag_tap_driver.sv
// Bench for jtag_tap_driver: drives scans into a behavioural DMI-style TAP
// (IDCODE=1, dtmcs=0x1071, bypass) and scoreboards the returned TDO words.
module tb_jtag_tap_driver;

   localparam int unsigned MaxLen = 64;
   localparam int unsigned LenW   = 7;

   logic              clk       = 1'b0;
   logic              trst_ni   = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ir    = 1'b0;
   logic              req_reset = 1'b0;
   logic [LenW-1:0]   req_len   = '0;
   logic [MaxLen-1:0] req_data  = '0;
   logic              rsp_ready = 1'b1;
   logic              req_ready;
   logic              rsp_valid;
   logic [MaxLen-1:0] rsp_data;
   logic              tck;
   logic              tms;
   logic              tdi;
   logic              tdo = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   jtag_tap_driver #(.ClkDiv(4), .MaxLen(MaxLen)) dut (
      .clk_i       (clk),
      .trst_ni     (trst_ni),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_ir_i    (req_ir),
      .req_reset_i (req_reset),
      .req_len_i   (req_len),
      .req_data_i  (req_data),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_data_o  (rsp_data),
      .tck_o       (tck),
      .tms_o       (tms),
      .tdi_o       (tdi),
      .tdo_i       (tdo)
   );

   // Behavioural TAP with a 5-bit IR
   localparam logic [3:0] TLR = 4'd0, RTI = 4'd1, SDR = 4'd2, CDR = 4'd3,
                          SHDR = 4'd4, E1DR = 4'd5, PDR = 4'd6, E2DR = 4'd7,
                          UDR = 4'd8, SIR = 4'd9, CIR = 4'd10, SHIR = 4'd11,
                          E1IR = 4'd12, PIR = 4'd13, E2IR = 4'd14, UIR = 4'd15;

   logic [3:0]  ts     = TLR;
   logic [4:0]  tap_ir = 5'h01;
   logic [4:0]  ir_sr  = '0;
   logic [31:0] dr_sr  = '0;

   function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
      case (s)
         TLR:     return m ? TLR  : RTI;
         RTI:     return m ? SDR  : RTI;
         SDR:     return m ? SIR  : CDR;
         CDR:     return m ? E1DR : SHDR;
         SHDR:    return m ? E1DR : SHDR;
         E1DR:    return m ? UDR  : PDR;
         PDR:     return m ? E2DR : PDR;
         E2DR:    return m ? UDR  : SHDR;
         UDR:     return m ? SDR  : RTI;
         SIR:     return m ? TLR  : CIR;
         CIR:     return m ? E1IR : SHIR;
         SHIR:    return m ? E1IR : SHIR;
         E1IR:    return m ? UIR  : PIR;
         PIR:     return m ? E2IR : PIR;
         E2IR:    return m ? UIR  : SHIR;
         default: return m ? SDR  : RTI;
      endcase
   endfunction

   always @(posedge tck) begin
      case (ts)
         TLR:  tap_ir <= 5'h01;
         CDR:  dr_sr  <= (tap_ir == 5'h01) ? 32'h1 : (tap_ir == 5'h10) ? 32'h1071 : 32'h0;
         SHDR: dr_sr  <= (tap_ir == 5'h01 || tap_ir == 5'h10) ? {tdi, dr_sr[31:1]} : {31'h0, tdi};
         CIR:  ir_sr  <= 5'b00101;
         SHIR: ir_sr  <= {tdi, ir_sr[4:1]};
         UIR:  tap_ir <= ir_sr;
         default: ;
      endcase
      ts <= tap_next(ts, tms);
   end

   always @(negedge tck) begin
      if (ts == SHDR) tdo <= dr_sr[0];
      else if (ts == SHIR) tdo <= ir_sr[0];
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Scoreboard and waveform monitor, sampling on the falling clk edge
   logic [63:0] exp_q[$];
   int          cyc            = 0;
   int          tck_rises      = 0;
   int          last_rise_cyc  = 0;
   int          prev_rise_cyc  = 0;
   int          last_fall_cyc  = 0;
   int          valid_rise_cyc = 0;
   int          rsp_count      = 0;
   logic        tck_prev       = 1'b0;
   logic        valid_prev     = 1'b0;
   logic [63:0] tms_hist       = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      tck_prev   <= tck;
      valid_prev <= rsp_valid;
      if (trst_ni) begin
         if (tck && !tck_prev) begin
            tck_rises     <= tck_rises + 1;
            tms_hist      <= {tms_hist[62:0], tms};
            prev_rise_cyc <= last_rise_cyc;
            last_rise_cyc <= cyc;
         end
         if (!tck && tck_prev) last_fall_cyc <= cyc;
         if (rsp_valid && !valid_prev) valid_rise_cyc <= cyc;
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_rsp: got data 0x%0h, expected no response", rsp_data);
            end else begin
               check("rsp_data", rsp_data, exp_q.pop_front());
            end
            rsp_count <= rsp_count + 1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 3000) begin
         tick();
         n++;
      end
      check("req_ready_wait", 64'(req_ready), 64'd1);
   endtask

   task automatic wait_rsp(input int target);
      int n = 0;
      while (rsp_count < target && n < 3000) begin
         tick();
         n++;
      end
      check("rsp_wait", 64'(rsp_count >= target), 64'd1);
   endtask

   task automatic issue(input logic ir, input logic rst, input int len, input logic [63:0] data,
                        input logic push, input logic [63:0] exp, output int acc, output int r0);
      wait_ready();
      req_ir    = ir;
      req_reset = rst;
      req_len   = LenW'(len);
      req_data  = data;
      req_valid = 1'b1;
      if (push) exp_q.push_back(exp);
      tick();
      acc       = cyc;
      r0        = tck_rises;
      req_valid = 1'b0;
      req_reset = 1'b0;
   endtask

   task automatic scan(input logic ir, input int len, input logic [63:0] data,
                       input logic [63:0] exp, input int tcks, output int acc);
      int r0;
      int tgt;
      tgt = rsp_count + 1;
      issue(ir, 1'b0, len, data, 1'b1, exp, acc, r0);
      wait_rsp(tgt);
      check("scan_tck_count", 64'(tck_rises - r0), 64'(tcks));
      check("tap_in_rti", 64'(ts), 64'(RTI));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int r0;
      int tgt;
      int n;
      logic [63:0] hold;
      logic stable;

      repeat (3) tick();
      check("reset_outputs", 64'({tck, tms, tdi, req_ready, rsp_valid}), 64'(5'b01000));
      check("reset_rsp_data", rsp_data, 64'd0);

      // Power-on TAP reset walk
      r0 = tck_rises;
      trst_ni = 1'b1;
      wait_ready();
      check("por_tck_count", 64'(tck_rises - r0), 64'd6);
      check("por_tms_seq", 64'(tms_hist[5:0]), 64'(6'b111110));
      check("tck_period", 64'(last_rise_cyc - prev_rise_cyc), 64'd8);
      check("idle_tck_tms", 64'({tck, tms}), 64'd0);

      // IDCODE read with exact timing
      scan(1'b0, 32, 64'h0, 64'h1, 37, acc);
      check("idcode_span", 64'(last_fall_cyc - acc), 64'd296);
      check("rsp_latency", 64'(valid_rise_cyc - last_fall_cyc), 64'd1);

      // dtmcs via IR 0x10
      scan(1'b1, 5, 64'h10, 64'h05, 11, acc);
      scan(1'b0, 32, 64'h0, 64'h1071, 37, acc);

      // Bypass adds one bit of delay
      scan(1'b1, 5, 64'h1f, 64'h05, 11, acc);
      scan(1'b0, 8, 64'hA5, 64'h4A, 13, acc);

      // Response held off by rsp_ready
      rsp_ready = 1'b0;
      tgt = rsp_count + 1;
      issue(1'b0, 1'b0, 8, 64'h3C, 1'b1, 64'h78, acc, r0);
      n = 0;
      while (!rsp_valid && n < 500) begin
         tick();
         n++;
      end
      hold   = rsp_data;
      stable = 1'b1;
      repeat (20) begin
         tick();
         if (!rsp_valid || rsp_data !== hold || req_ready) stable = 1'b0;
      end
      check("hold_stable", 64'(stable), 64'd1);
      check("hold_data", hold, 64'h78);
      rsp_ready = 1'b1;
      wait_rsp(tgt);

      // Zero-length request
      tgt = rsp_count + 1;
      issue(1'b0, 1'b0, 0, 64'hFFFF, 1'b1, 64'h0, acc, r0);
      wait_rsp(tgt);
      check("len0_latency", 64'(valid_rise_cyc - acc), 64'd1);
      check("len0_no_tck", 64'(tck_rises - r0), 64'd0);

      // Length above MaxLen clamps to 64 bits through bypass
      scan(1'b0, 100, 64'hF0F0_1234_5678_9ABC, 64'hE1E0_2468_ACF1_3578, 69, acc);

      // Explicit TAP reset request
      tgt = rsp_count + 1;
      issue(1'b0, 1'b1, 17, 64'hDEAD, 1'b1, 64'h0, acc, r0);
      wait_rsp(tgt);
      check("rstreq_tck_count", 64'(tck_rises - r0), 64'd6);
      check("rstreq_tms_seq", 64'(tms_hist[5:0]), 64'(6'b111110));
      check("rstreq_ir_idcode", 64'(tap_ir), 64'h01);
      scan(1'b0, 1, 64'h0, 64'h1, 6, acc);

      // Reset pulse in the middle of a shift
      scan(1'b1, 5, 64'h1f, 64'h05, 11, acc);
      issue(1'b0, 1'b0, 32, 64'hFFFF_FFFF, 1'b0, 64'h0, acc, r0);
      n = 0;
      while (tck_rises - r0 < 14 && n < 1000) begin
         tick();
         n++;
      end
      trst_ni = 1'b0;
      #1;
      check("midscan_outputs", 64'({tck, tms, tdi, req_ready, rsp_valid}), 64'(5'b01000));
      check("midscan_rsp_data", rsp_data, 64'd0);
      repeat (3) tick();
      r0 = tck_rises;
      trst_ni = 1'b1;
      wait_ready();
      check("rerun_tck_count", 64'(tck_rises - r0), 64'd6);
      check("rerun_tms_seq", 64'(tms_hist[5:0]), 64'(6'b111110));
      scan(1'b0, 32, 64'h0, 64'h1, 37, acc);

      repeat (5) tick();
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
